cdu_pulse_bank: RTL and testbench
=================================

# cdu_pulse_bank

Parametrised multi-channel successor to the single-axis CDU read-counter/pulse path. Holds NCH independent up/down angle read counters. Each counter step is queued in a signed per-channel pending-pulse accumulator. The queued steps are drained to the AGC as rate-limited, one-cycle +/- increment pulses through a round-robin arbiter. Sits between the per-axis error-angle/quadrant logic (source of UPLVL/DNLVL-style steps) and the AGC counter interface, replacing per-axis ±PGH generation.

## Interface
- NCH, 3: number of channels (≥1; 3 = IMU gimbals, 5 adds optics).
- WIDTH, 16: read-counter width, bits.
- PEND_W, 4: pending accumulator width, signed two's complement; range −2^(PEND_W−1) … 2^(PEND_W−1)−1.
- GAP, 4: minimum cycles between successive issued pulses, all channels combined (≥1).
- CLOCKH  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- UPLVL  in  NCH  per-channel count-up request, level-sampled each cycle.
- DNLVL  in  NCH  per-channel count-down request.
- CDUZ  in  NCH  per-channel zero; clears that channel's counter, accumulator, overflow flag.
- RDSEL  in  max(1,$clog2(NCH))  readback channel select.
- RDATA  out  WIDTH  combinational read counter of RDSEL; 0 if RDSEL ≥ NCH.
- pPGH  out  NCH  one-cycle +increment pulse, one-hot or zero.
- mPGH  out  NCH  one-cycle −increment pulse, one-hot or zero.
- OVF  out  NCH  sticky accumulator-saturation flag.

## Operation
- Step per channel: up=UPLVL&~DNLVL → +1; dn=DNLVL&~UPLVL → −1; both or neither → no step.
- Counter: cnt ± 1 modulo 2^WIDTH (0 − 1 = 2^WIDTH−1, all-ones + 1 = 0; no flag).
- Accumulator next = pend + step − issue, with issue = +1 if a + pulse is issued from this channel this edge, −1 if −, else 0. If the result exceeds the range: clamp to the bound, set OVF[ch]. Counter still steps.
- CDUZ[ch] has priority over step and issue: cnt=0, pend=0, OVF=0. The channel is not eligible for issue that edge.
- Issue engine:
  - timer counts down to 0, one per cycle.
  - At an edge where timer==0, eligible = channels with pend≠0 and CDUZ low, using pre-edge values.
  - If any channel is eligible, grant the first eligible after ptr (wrapping), set ptr=grant, load timer=GAP−1.
  - Register pPGH[grant]=1 if pend>0, else mPGH[grant]=1.
  - If nothing is eligible: timer stays 0, outputs 0.
- pPGH and mPGH are never both nonzero. At most one bit is set per cycle.

## Timing
- Reset (async assert, sync use after deassert): cnt=0, pend=0, OVF=0, pPGH=mPGH=0, timer=0, ptr=NCH−1 so channel 0 wins first.
- Step latency: counter and RDATA change 1 cycle after the sampled edge. The accumulator updates on the same edge.
- Pulse latency: a step at edge k makes pend≠0 after k. The earliest pulse is decided at edge k+1 and is high for the cycle after k+1. This gives 2 cycles from request to pulse when idle.
- Pulse spacing: exactly GAP cycles between issue edges while work is pending. GAP=1 gives back-to-back pulses.
- Simultaneous step and issue on one channel net out (e.g. pend=+1, up step, + issue → pend stays +1).
- Reset mid-burst: pulses stop immediately (async). No pulse is issued on the first edge after release unless pend≠0, which is impossible because pend=0.
- CDUZ during a pending pulse output: the already-registered pulse still completes its cycle. No further pulses follow.

## Structure
- The shared package cdu_pkg holds:
  - localparam function clog2-safe select width.
  - typedef for the per-channel pend type parametrised by PEND_W, or documented width constants if the toolflow lacks parametrised typedefs.
  - Saturating-add helper function.
- Sub-module cdu_rr_arbiter (NCH req in, ptr in, grant one-hot + index out, combinational). It is reused by future multi-channel CDU blocks.
- The top is generate-loop per channel: counter, accumulator, OVF.

## Test plan
- Reset then UPLVL[0] held 3 cycles, NCH=3, GAP=4:
  - cnt0=3.
  - Exactly 3 pPGH[0] pulses, 4 cycles apart.
  - First pulse 2 cycles after first step.
  - pend0 returns to 0.
- Counter wrap, WIDTH=16: 1 DNLVL[1] step from reset → RDATA(RDSEL=1)=0xFFFF, one mPGH[1] pulse; then 1 UPLVL[1] step → RDATA=0x0000, one pPGH[1].
- Round-robin: pend = +2/−1/+1 on ch0/1/2 loaded simultaneously → pulse order p0, m1, p2, p0, each GAP apart.
- Saturation, PEND_W=4, GAP=16: 10 consecutive up steps on ch2 → pend clamps at 7, OVF[2]=1, cnt2=10. The bench checks the exact pulse count against the cycle-by-cycle accumulator model. OVF stays set until CDUZ[2].
- Both UPLVL and DNLVL high on ch0 for 5 cycles → cnt0 unchanged, no pulses. CDUZ[0] during a pending burst → cnt0=0 and no pulse after the one already in flight.
- Async reset asserted mid-burst → all outputs 0 within the same cycle; after release, RDATA=0 and no pulses until a new step.

Source files
------------

// File: rtl/cdu_pkg.sv
// Shared helpers for the CDU pulse-path blocks: select widths and saturating
// arithmetic for the signed pending-pulse accumulators.
package cdu_pkg;

  // Default accumulator width; accumulators are logic signed [PEND_W-1:0]
  // in the instantiating module, since packages cannot hold parametrised types.
  localparam int PEND_W_DEFAULT = 4;

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int pend_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int pend_min(input int w);
    return -(1 << (w - 1));
  endfunction

  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    s = a + b;
    if (s > pend_max(w)) return pend_max(w);
    if (s < pend_min(w)) return pend_min(w);
    return s;
  endfunction

endpackage

// File: rtl/cdu_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// wrapping, and reports the grant both one-hot and as an index.
module cdu_rr_arbiter import cdu_pkg::*; #(
  parameter  int NCH = 3,
  localparam int SW  = sel_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [SW-1:0]  idx,
  output logic           any
);

  logic [SW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = SW'((int'(ptr) + i) % NCH);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/cdu_pulse_bank.sv
// Multi-channel CDU read counters with signed pending-pulse accumulators,
// drained as rate-limited +/- increment pulses through a round-robin arbiter.
module cdu_pulse_bank import cdu_pkg::*; #(
  parameter  int NCH    = 3,
  parameter  int WIDTH  = 16,
  parameter  int PEND_W = PEND_W_DEFAULT,
  parameter  int GAP    = 4,
  localparam int SW     = sel_w(NCH),
  localparam int TW     = sel_w(GAP)
) (
  input  logic             CLOCKH,
  input  logic             rst_n,
  input  logic [NCH-1:0]   UPLVL,
  input  logic [NCH-1:0]   DNLVL,
  input  logic [NCH-1:0]   CDUZ,
  input  logic [SW-1:0]    RDSEL,
  output logic [WIDTH-1:0] RDATA,
  output logic [NCH-1:0]   pPGH,
  output logic [NCH-1:0]   mPGH,
  output logic [NCH-1:0]   OVF
);

  logic [WIDTH-1:0] cnt [NCH];
  logic [NCH-1:0]   nz, pos, elig, grant, iss_p, iss_m;
  logic [SW-1:0]    ptr, gidx;
  logic [TW-1:0]    timer;
  logic             any, fire;

  // A channel being zeroed this edge must not be drained.
  assign elig = nz & ~CDUZ;

  cdu_rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign fire  = (timer == '0) && any;
  assign iss_p = fire ? (grant & pos)  : '0;
  assign iss_m = fire ? (grant & ~pos) : '0;

  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      ptr   <= SW'(NCH - 1);
      pPGH  <= '0;
      mPGH  <= '0;
    end else begin
      pPGH <= iss_p;
      mPGH <= iss_m;
      if (fire) begin
        timer <= TW'(GAP - 1);
        ptr   <= gidx;
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0]         cnt_q;
    logic signed [PEND_W-1:0] pend, pend_d;
    logic                     ovf_q, ovf_d, up, dn;
    int                       step, iss, sum, sat;

    assign up = UPLVL[g] & ~DNLVL[g];
    assign dn = DNLVL[g] & ~UPLVL[g];

    always_comb begin
      step   = up ? 1 : (dn ? -1 : 0);
      iss    = iss_p[g] ? 1 : (iss_m[g] ? -1 : 0);
      sum    = int'(pend) + step - iss;
      sat    = sat_add(int'(pend), step - iss, PEND_W);
      pend_d = PEND_W'(sat);
      ovf_d  = (sat != sum);
    end

    always_ff @(posedge CLOCKH or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        pend  <= '0;
        ovf_q <= 1'b0;
      end else if (CDUZ[g]) begin
        cnt_q <= '0;
        pend  <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (up)      cnt_q <= cnt_q + 1'b1;
        else if (dn) cnt_q <= cnt_q - 1'b1;
        pend <= pend_d;
        if (ovf_d) ovf_q <= 1'b1;
      end
    end

    assign cnt[g] = cnt_q;
    assign OVF[g] = ovf_q;
    assign nz[g]  = (pend != '0);
    assign pos[g] = ~pend[PEND_W-1];
  end

  always_comb begin
    RDATA = '0;
    if (int'(RDSEL) < NCH) RDATA = cnt[RDSEL];
  end

endmodule

// File: tb/tb_cdu_pulse_bank.sv
// Scoreboarded bench for cdu_pulse_bank: directed scenarios plus random
// up/down/zero traffic against a per-edge behavioural model.
module tb_cdu_pulse_bank;

  localparam int NCH    = 3;
  localparam int WIDTH  = 16;
  localparam int PEND_W = 4;
  localparam int GAP    = 4;
  localparam int SW     = 2;
  localparam int PMAX   = (1 << (PEND_W - 1)) - 1;
  localparam int PMIN   = -(1 << (PEND_W - 1));

  logic             CLOCKH = 1'b0;
  logic             rst_n  = 1'b0;
  logic [NCH-1:0]   UPLVL  = '0;
  logic [NCH-1:0]   DNLVL  = '0;
  logic [NCH-1:0]   CDUZ   = '0;
  logic [SW-1:0]    RDSEL  = '0;
  logic [WIDTH-1:0] RDATA;
  logic [NCH-1:0]   pPGH, mPGH, OVF;

  cdu_pulse_bank #(.NCH(NCH), .WIDTH(WIDTH), .PEND_W(PEND_W), .GAP(GAP)) dut (
    .CLOCKH (CLOCKH),
    .rst_n  (rst_n),
    .UPLVL  (UPLVL),
    .DNLVL  (DNLVL),
    .CDUZ   (CDUZ),
    .RDSEL  (RDSEL),
    .RDATA  (RDATA),
    .pPGH   (pPGH),
    .mPGH   (mPGH),
    .OVF    (OVF)
  );

  always #5 CLOCKH = ~CLOCKH;

  typedef struct {
    int stamp;
    int ch;
    bit minus;
  } pulse_t;

  pulse_t exp_q[$];
  int     obs_log[$];
  int     obs_stamp[$];
  int     obs_p[NCH];
  int     obs_m[NCH];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     mon_edge = 0;

  // Reference model: counters, accumulators, flags, drain pacing.
  int m_cnt[NCH];
  int m_pend[NCH];
  bit m_ovf[NCH];
  int m_timer, m_ptr, m_gch;
  int m_edge = 0;
  bit m_fired;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c]  = 0;
      m_pend[c] = 0;
      m_ovf[c]  = 1'b0;
    end
    m_timer = 0;
    m_ptr   = NCH - 1;
    m_fired = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_edge();
    int step, iss, v;
    m_edge++;
    m_fired = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_timer == 0) begin
      for (int i = 1; i <= NCH; i++) begin
        int c = (m_ptr + i) % NCH;
        if (!m_fired && m_pend[c] != 0 && !CDUZ[c]) begin
          m_fired = 1'b1;
          m_gch   = c;
        end
      end
      if (m_fired) begin
        m_ptr   = m_gch;
        m_timer = GAP - 1;
        exp_q.push_back('{m_edge, m_gch, m_pend[m_gch] < 0});
      end
    end else begin
      m_timer--;
    end
    for (int c = 0; c < NCH; c++) begin
      if (CDUZ[c]) begin
        m_cnt[c]  = 0;
        m_pend[c] = 0;
        m_ovf[c]  = 1'b0;
      end else begin
        step = (UPLVL[c] && !DNLVL[c]) ? 1 : ((DNLVL[c] && !UPLVL[c]) ? -1 : 0);
        iss  = (m_fired && m_gch == c) ? ((m_pend[c] > 0) ? 1 : -1) : 0;
        m_cnt[c] = (m_cnt[c] + step) & ((1 << WIDTH) - 1);
        v = m_pend[c] + step - iss;
        if (v > PMAX) begin v = PMAX; m_ovf[c] = 1'b1; end
        if (v < PMIN) begin v = PMIN; m_ovf[c] = 1'b1; end
        m_pend[c] = v;
      end
    end
  endfunction

  function automatic bit model_busy();
    for (int c = 0; c < NCH; c++) if (m_pend[c] != 0) return 1'b1;
    return exp_q.size() != 0;
  endfunction

  function automatic void check_state();
    logic [NCH-1:0] ov;
    int rd;
    for (int c = 0; c < NCH; c++) ov[c] = m_ovf[c];
    rd = (int'(RDSEL) < NCH) ? m_cnt[RDSEL] : 0;
    chk("rdata", 64'(RDATA), 64'(rd));
    chk("ovf", 64'(OVF), 64'(ov));
  endfunction

  task automatic cycle();
    @(posedge CLOCKH);
    model_edge();
    @(negedge CLOCKH);
    check_state();
  endtask

  task automatic drain();
    int n = 0;
    while (model_busy() && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_bound", 64'(n >= 200), 64'(0));
    repeat (GAP + 2) cycle();
  endtask

  function automatic int total_pulses();
    int t = 0;
    for (int c = 0; c < NCH; c++) t += obs_p[c] + obs_m[c];
    return t;
  endfunction

  // Monitor: pops the expected pulse due at this edge, flags strays.
  initial begin : monitor
    pulse_t         e;
    logic [NCH-1:0] xp, xm;
    for (int c = 0; c < NCH; c++) begin obs_p[c] = 0; obs_m[c] = 0; end
    forever begin
      @(posedge CLOCKH);
      mon_edge++;
      #1;
      if (exp_q.size() > 0 && exp_q[0].stamp == mon_edge) begin
        e  = exp_q.pop_front();
        xp = '0;
        xm = '0;
        if (e.minus) xm[e.ch] = 1'b1;
        else         xp[e.ch] = 1'b1;
        chk("pulse", 64'({pPGH, mPGH}), 64'({xp, xm}));
      end else if ((pPGH | mPGH) != '0) begin
        chk("unexpected_pulse", 64'({pPGH, mPGH}), 64'(0));
      end
      for (int c = 0; c < NCH; c++) begin
        if (pPGH[c]) begin obs_p[c]++; obs_log.push_back(c * 2);     obs_stamp.push_back(mon_edge); end
        if (mPGH[c]) begin obs_m[c]++; obs_log.push_back(c * 2 + 1); obs_stamp.push_back(mon_edge); end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int base, idx, e_step, n, t0;
    bit fired;
    int rr_code[4];
    model_reset();

    repeat (3) cycle();
    rst_n = 1'b1;
    chk("reset_pulses", 64'({pPGH, mPGH}), 64'(0));
    chk("reset_ovf", 64'(OVF), 64'(0));
    for (int s = 0; s < 4; s++) begin
      RDSEL = SW'(s);
      #1;
      chk("reset_rdata", 64'(RDATA), 64'(0));
    end
    RDSEL = '0;

    // Three up steps on ch0: pulses at step edge +1, +1+GAP, +1+2*GAP.
    base   = obs_p[0];
    idx    = obs_log.size();
    e_step = m_edge + 1;
    UPLVL[0] = 1'b1;
    repeat (3) cycle();
    UPLVL[0] = 1'b0;
    drain();
    chk("t1_cnt", 64'(RDATA), 64'(3));
    chk("t1_npulse", 64'(obs_p[0] - base), 64'(3));
    chk("t1_logsize", 64'(obs_log.size() - idx), 64'(3));
    for (int i = 0; i < 3 && idx + i < obs_stamp.size(); i++)
      chk("t1_timing", 64'(obs_stamp[idx + i] - e_step), 64'(1 + GAP * i));

    // Down wrap then up wrap on ch1.
    RDSEL = 2'd1;
    base = obs_m[1];
    DNLVL[1] = 1'b1;
    cycle();
    DNLVL[1] = 1'b0;
    drain();
    chk("wrap_dn_rdata", 64'(RDATA), 64'(16'hFFFF));
    chk("wrap_dn_pulse", 64'(obs_m[1] - base), 64'(1));
    base = obs_p[1];
    UPLVL[1] = 1'b1;
    cycle();
    UPLVL[1] = 1'b0;
    drain();
    chk("wrap_up_rdata", 64'(RDATA), 64'(0));
    chk("wrap_up_pulse", 64'(obs_p[1] - base), 64'(1));

    // Up and down together cancel.
    RDSEL = 2'd0;
    t0 = total_pulses();
    UPLVL[0] = 1'b1;
    DNLVL[0] = 1'b1;
    repeat (5) cycle();
    UPLVL[0] = 1'b0;
    DNLVL[0] = 1'b0;
    drain();
    chk("both_cnt", 64'(RDATA), 64'(3));
    chk("both_pulses", 64'(total_pulses() - t0), 64'(0));

    // Zero ch0 while its first pulse is in flight.
    base = obs_p[0];
    UPLVL[0] = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!(m_fired && m_gch == 0) && n < 10);
    chk("cduz_fire_bound", 64'(n < 10), 64'(1));
    UPLVL[0] = 1'b0;
    CDUZ[0]  = 1'b1;
    cycle();
    CDUZ[0] = 1'b0;
    drain();
    chk("cduz_cnt", 64'(RDATA), 64'(0));
    chk("cduz_pulses", 64'(obs_p[0] - base), 64'(1));

    // Saturation on ch2: 14 steps, 3 clamped away.
    RDSEL = 2'd2;
    base = obs_p[2];
    UPLVL[2] = 1'b1;
    repeat (14) cycle();
    UPLVL[2] = 1'b0;
    chk("sat_ovf", 64'(OVF[2]), 64'(1));
    chk("sat_cnt", 64'(RDATA), 64'(14));
    drain();
    chk("sat_pulses", 64'(obs_p[2] - base), 64'(11));
    chk("sat_ovf_sticky", 64'(OVF[2]), 64'(1));
    CDUZ[2] = 1'b1;
    cycle();
    CDUZ[2] = 1'b0;
    chk("sat_ovf_clear", 64'(OVF[2]), 64'(0));
    chk("sat_cnt_clear", 64'(RDATA), 64'(0));

    // Async reset while a pulse is on the outputs.
    UPLVL[0] = 1'b1;
    DNLVL[1] = 1'b1;
    repeat (2) cycle();
    UPLVL[0] = 1'b0;
    DNLVL[1] = 1'b0;
    fired = 1'b0;
    n = 0;
    while (!fired && n < 20) begin
      @(posedge CLOCKH);
      model_edge();
      fired = m_fired;
      if (!fired) begin @(negedge CLOCKH); check_state(); end
      n++;
    end
    chk("arst_fire_bound", 64'(fired), 64'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_pulses", 64'({pPGH, mPGH}), 64'(0));
    chk("arst_ovf", 64'(OVF), 64'(0));
    @(negedge CLOCKH);
    repeat (2) cycle();
    rst_n = 1'b1;
    t0 = total_pulses();
    repeat (8) cycle();
    chk("arst_quiet", 64'(total_pulses() - t0), 64'(0));
    for (int s = 0; s < NCH; s++) begin
      RDSEL = SW'(s);
      #1;
      chk("arst_rdata", 64'(RDATA), 64'(0));
    end

    // Round robin from fresh pointer: p0, m1, p2, p0.
    rr_code = '{0, 3, 4, 0};
    idx = obs_log.size();
    UPLVL = 3'b101;
    DNLVL = 3'b010;
    cycle();
    UPLVL = 3'b001;
    DNLVL = 3'b000;
    cycle();
    UPLVL = 3'b000;
    drain();
    chk("rr_count", 64'(obs_log.size() - idx), 64'(4));
    for (int i = 0; i < 4 && idx + i < obs_log.size(); i++) begin
      chk("rr_order", 64'(obs_log[idx + i]), 64'(rr_code[i]));
      if (i > 0) chk("rr_spacing", 64'(obs_stamp[idx + i] - obs_stamp[idx + i - 1]), 64'(GAP));
    end

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < NCH; c++) begin
        UPLVL[c] = ($urandom_range(0, 3) == 0);
        DNLVL[c] = ($urandom_range(0, 4) == 0);
        CDUZ[c]  = ($urandom_range(0, 40) == 0);
      end
      RDSEL = SW'($urandom_range(0, 3));
      cycle();
    end
    UPLVL = '0;
    DNLVL = '0;
    CDUZ  = '0;
    drain();
    chk("final_queue", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
